gf180mcu_fd_sc_mcu7t5v0__dbi_rx: RTL and testbench
==================================================

# gf180mcu_fd_sc_mcu7t5v0__dbi_rx

Receive-side data-bus-inversion (DBI-DC) decoder for the mcu7t5v0 functional library. It accepts a transmitted word plus its invert flag, restores the original data by conditional complement, and buffers it in a 2-entry skid FIFO under valid/ready flow control. An optional checker flags words that break the encoder's zero-count rule. It sits at the receiving end of any on-chip bus driven through an inverting DBI encoder.

## Interface
- WIDTH, 8: data width; even, 4..32.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- IN_VALID  input  1  transmit side presents a word.
- IN_READY  output  1  block can accept a word (count < 2).
- I  input  WIDTH  transmitted (possibly inverted) word.
- INV  input  1  invert flag sent with I.
- OUT_VALID  output  1  decoded word available (count > 0).
- OUT_READY  input  1  consumer accepts the head word.
- Z  output  WIDTH  decoded word at FIFO head; 0 when OUT_VALID=0.
- ERR  output  1  one-cycle pulse: accepted word violated the DBI rule.
- ERR_CNT  output  8  saturating violation count.
- CNT_CLR  input  1  synchronous clear of ERR_CNT.
- VDD, VSS  inout  1  supply pins, functionally unused.

## Operation
- Push: IN_VALID & IN_READY. Stored word = INV ? ~I : I.
- Pop: OUT_VALID & OUT_READY. Head advances.
- FIFO: 2 entries, wr/rd pointers 1 bit each, count 0..2. States EMPTY (0), ONE (1), FULL (2).
- EMPTY: push -> ONE; pop impossible.
- ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, new word becomes head next cycle.
- FULL: IN_READY=0, no push; pop -> ONE.
- Ordering strictly FIFO; no word dropped or duplicated.
- DBI rule check on each pushed word: number of zero bits in I must be <= WIDTH/2. Violation sets ERR high for the following cycle and increments ERR_CNT.
- ERR_CNT saturates at 255. CNT_CLR and violation in the same cycle -> ERR_CNT = 1. CNT_CLR alone -> 0.
- INV is not checked against I beyond the zero-count rule.

## Timing
- Reset values: IN_READY=1 (combinational from count 0), OUT_VALID=0, Z=0, ERR=0, ERR_CNT=0, pointers and count 0.
- RST mid-operation discards all stored words in the same edge; stored data need not be cleared, but Z is masked to 0.
- Latency: word pushed at edge n is visible on Z with OUT_VALID=1 after edge n (next cycle) if FIFO was empty.
- IN_READY and OUT_VALID depend only on registered count; no combinational path from OUT_READY to IN_READY.
- Full throughput: one word per cycle when OUT_READY held high.
- ERR asserts exactly one cycle after the violating push edge.

## Configuration
- GF180MCU_FD_SC_MCU7T5V0__DBI_RX_CHECK_EN defined: zero-count checker, ERR and ERR_CNT implemented as above.
- Undefined: checker and counter removed; ERR tied 0, ERR_CNT tied 0, CNT_CLR ignored; FIFO and decode unchanged.

## Test plan
- Reset: RST=1 two cycles -> IN_READY=1, OUT_VALID=0, Z=0x00, ERR_CNT=0.
- Decode: push I=0x0F INV=1, then I=0xA5 INV=0, OUT_READY=1 -> Z=0xF0 then 0xA5, one cycle each, in order.
- Backpressure: OUT_READY=0, push 3 words -> IN_READY=0 after second push, third held; release OUT_READY -> all three delivered in order.
- Simultaneous push/pop at count 1 over 10 cycles -> count stays 1, OUT_VALID continuously 1, no loss.
- Checker (macro on): push I=0x01 (7 zeros) -> ERR pulse next cycle, ERR_CNT=1; 300 violations -> ERR_CNT=255; CNT_CLR with violation -> ERR_CNT=1.
- Reset mid-stream while FULL -> next cycle OUT_VALID=0, IN_READY=1, Z=0; macro off -> ERR and ERR_CNT stay 0 for violating words.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbi_rx.sv
// DBI-DC receive decoder: conditional complement of I by INV, buffered in a 2-entry skid FIFO.
// Optional zero-count checker (ERR/ERR_CNT) enabled by GF180MCU_FD_SC_MCU7T5V0__DBI_RX_CHECK_EN.
module gf180mcu_fd_sc_mcu7t5v0__dbi_rx #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] I,
   input  logic             INV,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] Z,
   output logic             ERR,
   output logic [7:0]       ERR_CNT,
   input  logic             CNT_CLR,
   inout  wire              VDD,
   inout  wire              VSS
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]       count_reg;
   logic [1:0]       count_next;
   logic             wr_ptr_reg;
   logic             wr_ptr_next;
   logic             rd_ptr_reg;
   logic             rd_ptr_next;
   logic [WIDTH-1:0] mem_reg [0:1];
   logic [WIDTH-1:0] decoded;
   logic             push;
   logic             pop;

   // Per-bit conditional complement restores the pre-encoder word.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign decoded[gi] = I[gi] ^ INV;
   end

   // Handshake flags come only from registered count, so no ready-to-ready path exists.
   assign IN_READY  = (count_reg != FULL);
   assign OUT_VALID = (count_reg != EMPTY);
   assign push      = IN_VALID & IN_READY;
   assign pop       = OUT_VALID & OUT_READY;

   always_comb begin
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg ^ push;
      rd_ptr_next = rd_ptr_reg ^ pop;
      case (count_reg)
         EMPTY: begin
            if (push) count_next = ONE;
         end
         ONE: begin
            if (push && !pop)      count_next = FULL;
            else if (pop && !push) count_next = EMPTY;
         end
         FULL: begin
            if (pop) count_next = ONE;
         end
         default: count_next = EMPTY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_reg  <= EMPTY;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         count_reg  <= count_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage is not reset; stale contents are hidden by the OUT_VALID mask on Z.
   always_ff @(posedge CLK) begin
      if (push) mem_reg[wr_ptr_reg] <= decoded;
   end

   assign Z = OUT_VALID ? mem_reg[rd_ptr_reg] : '0;

`ifdef GF180MCU_FD_SC_MCU7T5V0__DBI_RX_CHECK_EN
   localparam int ZW = $clog2(WIDTH + 1);

   logic [ZW-1:0] zero_cnt;
   logic          violation;
   logic          err_reg;
   logic [7:0]    err_cnt_reg;
   logic [7:0]    err_cnt_next;

   // The rule is checked on the line word I, not on the decoded word.
   always_comb begin
      zero_cnt = '0;
      for (int b = 0; b < WIDTH; b++) begin
         zero_cnt = zero_cnt + ZW'(~I[b]);
      end
   end

   assign violation = push && (zero_cnt > ZW'(WIDTH / 2));

   always_comb begin
      err_cnt_next = err_cnt_reg;
      if (CNT_CLR)
         err_cnt_next = violation ? 8'd1 : 8'd0;
      else if (violation && (err_cnt_reg != 8'hFF))
         err_cnt_next = err_cnt_reg + 8'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         err_reg     <= 1'b0;
         err_cnt_reg <= 8'd0;
      end else begin
         err_reg     <= violation;
         err_cnt_reg <= err_cnt_next;
      end
   end

   assign ERR     = err_reg;
   assign ERR_CNT = err_cnt_reg;

   logic unused_supply;
   assign unused_supply = VDD ^ VSS;
`else
   assign ERR     = 1'b0;
   assign ERR_CNT = 8'd0;

   logic unused_supply;
   assign unused_supply = VDD ^ VSS ^ CNT_CLR;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dbi_rx.sv
// Directed table-driven bench for the DBI receive decoder and its skid FIFO.
module tb_gf180mcu_fd_sc_mcu7t5v0__dbi_rx;

`ifdef GF180MCU_FD_SC_MCU7T5V0__DBI_RX_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] i_word;
   logic       inv;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] z;
   logic       err;
   logic [7:0] err_cnt;
   logic       cnt_clr;
   wire        vdd;
   wire        vss;

   assign vdd = 1'b1;
   assign vss = 1'b0;

   gf180mcu_fd_sc_mcu7t5v0__dbi_rx #(.WIDTH(8)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
      .I(i_word), .INV(inv), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .Z(z), .ERR(err), .ERR_CNT(err_cnt), .CNT_CLR(cnt_clr),
      .VDD(vdd), .VSS(vss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       iv;
      logic [7:0] i;
      logic       inv;
      logic       ordy;
      logic       clr;
      logic       chk;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_z;
      logic       e_err;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t tbl [22];
   int   n_vec;
   int   n_bad;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [7:0] w, input logic iw, input logic ordy, input logic clr);
      rst       = r;
      in_valid  = iv;
      i_word    = w;
      inv       = iw;
      out_ready = ordy;
      cnt_clr   = clr;
   endtask

   // Expected values in each row are what the outputs show during that row's cycle,
   // before the row's inputs are clocked in.
   initial begin
      n_vec = 0;
      n_bad = 0;
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      //            rst iv  i      inv  ordy clr  chk   ir   ov   z      err  cnt
      tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,8'd0};
      tbl[1]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd0};
      tbl[2]  = '{1'b0,1'b1,8'h0F,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd0};
      tbl[3]  = '{1'b0,1'b1,8'hA5,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'hF0,1'b0,8'd0};
      tbl[4]  = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'hA5,1'b0,8'd0};
      tbl[5]  = '{1'b0,1'b1,8'h3C,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd0};
      tbl[6]  = '{1'b0,1'b1,8'h7E,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,8'h3C,1'b0,8'd0};
      tbl[7]  = '{1'b0,1'b1,8'hFF,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,8'h3C,1'b0,8'd0};
      tbl[8]  = '{1'b0,1'b1,8'hFF,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,8'h3C,1'b0,8'd0};
      tbl[9]  = '{1'b0,1'b1,8'hFF,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,8'h3C,1'b0,8'd0};
      tbl[10] = '{1'b0,1'b1,8'hFF,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'h81,1'b0,8'd0};
      tbl[11] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'hFF,1'b0,8'd0};
      tbl[12] = '{1'b0,1'b1,8'h01,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd0};
      tbl[13] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'h01,1'b1,8'd1};
      tbl[14] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd1};
      tbl[15] = '{1'b0,1'b1,8'h01,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd0};
      tbl[16] = '{1'b0,1'b1,8'h02,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'h01,1'b1,8'd1};
      tbl[17] = '{1'b0,1'b1,8'h04,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1,8'h02,1'b1,8'd2};
      tbl[18] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'h04,1'b1,8'd1};
      tbl[19] = '{1'b0,1'b1,8'h0F,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd1};
      tbl[20] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b1,8'hF0,1'b0,8'd1};
      tbl[21] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b0,8'd1};

      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         if (tbl[k].chk) begin
            check("in_ready",  k, 32'(in_ready),  32'(tbl[k].e_ir));
            check("out_valid", k, 32'(out_valid), 32'(tbl[k].e_ov));
            check("z",         k, 32'(z),         32'(tbl[k].e_z));
            check("err",       k, 32'(err),       32'(tbl[k].e_err & CHK));
            check("err_cnt",   k, 32'(err_cnt),   CHK ? 32'(tbl[k].e_cnt) : 32'd0);
         end
         drive(tbl[k].rst, tbl[k].iv, tbl[k].i, tbl[k].inv, tbl[k].ordy, tbl[k].clr);
         $display("vec %0d: rst=%0b iv=%0b i=%02h inv=%0b ordy=%0b clr=%0b | ir=%0b ov=%0b z=%02h err=%0b cnt=%0d",
                  k, tbl[k].rst, tbl[k].iv, tbl[k].i, tbl[k].inv, tbl[k].ordy, tbl[k].clr,
                  in_ready, out_valid, z, err, err_cnt);
      end

      // Streaming at count 1: push and pop every cycle for ten cycles.
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check("pp_ov",  100 + k, 32'(out_valid), 32'd1);
            check("pp_ir",  100 + k, 32'(in_ready),  32'd1);
            check("pp_z",   100 + k, 32'(z),         32'(8'hF0 | 8'(k - 1)));
            check("pp_err", 100 + k, 32'(err),       32'd0);
            $display("stream %0d: z=%02h ov=%0b ir=%0b", k, z, out_valid, in_ready);
         end
         if (k < 10) drive(1'b0, 1'b1, 8'hF0 | 8'(k), 1'b0, 1'b1, 1'b0);
         else        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      @(negedge clk);
      check("pp_drain", 111, 32'(out_valid), 32'd0);

      // 300 back-to-back violating words; counter starts from 1 and must pin at 255.
      for (int k = 0; k < 300; k++) begin
         check("sat_cnt", 200 + k, 32'(err_cnt), CHK ? 32'((1 + k > 255) ? 255 : 1 + k) : 32'd0);
         if (k > 0) begin
            check("sat_err", 200 + k, 32'(err),       32'(CHK));
            check("sat_z",   200 + k, 32'(z),         32'h01);
         end
         drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
      end
      $display("saturate: err=%0b cnt=%0d", err, err_cnt);
      check("sat_final_cnt", 500, 32'(err_cnt), CHK ? 32'd255 : 32'd0);
      check("sat_final_err", 500, 32'(err),     32'(CHK));
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("sat_err_drop", 501, 32'(err), 32'd0);

      // Fill the FIFO, then reset while full.
      drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("full_ir", 600, 32'(in_ready),  32'd0);
      check("full_ov", 600, 32'(out_valid), 32'd1);
      check("full_z",  600, 32'(z),         32'h3C);
      drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("rst_ir",  601, 32'(in_ready),  32'd1);
      check("rst_ov",  601, 32'(out_valid), 32'd0);
      check("rst_z",   601, 32'(z),         32'h00);
      check("rst_err", 601, 32'(err),       32'd0);
      check("rst_cnt", 601, 32'(err_cnt),   32'd0);
      $display("reset-full: ir=%0b ov=%0b z=%02h cnt=%0d", in_ready, out_valid, z, err_cnt);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("post_rst_ov", 602, 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
